// File: rtl/mem_miss_arbiter_pkg.sv
// Shared types and constants for the multi-port cache miss arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;

endpackage

// File: rtl/mem_miss_arbiter_if.sv
// Cache-side request/fill signals and memory-side bus of the miss arbiter.
// slave = arbiter view, master = caches plus memory view.
interface mem_miss_arbiter_if #(
    parameter int NPORTS = 2,
    parameter int AW     = 16,
    parameter int DW     = 16
);
    logic [NPORTS-1:0]    req_valid;
    logic [NPORTS-1:0]    req_write;
    logic [NPORTS*AW-1:0] req_addr;
    logic [NPORTS*DW-1:0] req_wdata;
    logic [NPORTS-1:0]    stall;
    logic [NPORTS-1:0]    done;
    logic [NPORTS-1:0]    fill_we;
    logic [NPORTS-1:0]    fill_tag_we;
    logic [AW-1:0]        fill_addr;
    logic [DW-1:0]        fill_data;
    logic                 mem_en;
    logic                 mem_wr;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic [DW-1:0]        mem_rdata;
    logic                 mem_rvalid;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_rvalid,
        output stall, done, fill_we, fill_tag_we, fill_addr, fill_data,
               mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_rvalid,
        input  stall, done, fill_we, fill_tag_we, fill_addr, fill_data,
               mem_en, mem_wr, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_miss_arbiter_rr_arbiter.sv
// Request arbiter: fixed lowest-index priority or round-robin after a pointer.
// The pointer moves to the grantee only when the grant is actually taken.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N    = 2,
    parameter int MODE = PRIO_FIXED
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    input  logic         upd_i,
    output logic [N-1:0] grant_o
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Pick one requester: lowest index, or the first one after the pointer in RR mode
    always_comb begin : pick_blk
        logic          found;
        logic [PW-1:0] cand;
        grant_o = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            if (MODE == PRIO_RR) begin
                cand = PW'((int'(ptr_q) + 1 + i) % N);
            end else begin
                cand = PW'(i);
            end
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                ptr_d         = cand;
            end
        end
    end

    // Pointer starts at the last port so port 0 wins first after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= PW'(N - 1);
        end else if (upd_i && |req_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mem_miss_arbiter.sv
// Arbitrates block-fill misses and write-through stores from NPORTS caches
// onto one shared memory port. Fills are issued one word per cycle while
// returned words are passed straight through to the granted cache.
module mem_miss_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NPORTS      = 2,
    parameter int AW          = 16,
    parameter int DW          = 16,
    parameter int BLOCK_WORDS = 8,
    parameter int PRIO_MODE   = PRIO_FIXED
) (
    input  logic clk,
    input  logic rst,
    mem_miss_arbiter_if.slave bus
);
    localparam int CW   = $clog2(BLOCK_WORDS) + 1;
    localparam int WB   = DW / 8;
    localparam int OFFW = $clog2(BLOCK_WORDS * WB);

    state_t            state_q, state_d;
    logic [NPORTS-1:0] gnt_q, gnt_d, arb_gnt;
    logic [AW-1:0]     addr_q, addr_d, sel_addr;
    logic [DW-1:0]     wdata_q, wdata_d, sel_wdata;
    logic              sel_write;
    logic [CW-1:0]     issue_q, issue_d;
    logic [CW-1:0]     recv_q, recv_d;
    logic [AW-1:0]     block_base;
    logic              take;

    assign take       = (state_q == IDLE) && (|bus.req_valid);
    assign block_base = {addr_q[AW-1:OFFW], {OFFW{1'b0}}};
    assign bus.done   = (state_q == DONE) ? gnt_q : '0;
    assign bus.stall  = bus.req_valid & ~bus.done;

    rr_arbiter #(.N(NPORTS), .MODE(PRIO_MODE)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_i   (bus.req_valid),
        .upd_i   (take),
        .grant_o (arb_gnt)
    );

    // Route the granted port's request onto the latch inputs (grant is one-hot)
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            if (arb_gnt[i]) begin
                sel_addr  = sel_addr  | bus.req_addr[i*AW +: AW];
                sel_wdata = sel_wdata | bus.req_wdata[i*DW +: DW];
                sel_write = sel_write | bus.req_write[i];
            end
        end
    end

    // Sequencer: next state, fill counters and every memory/fill output
    always_comb begin
        state_d         = state_q;
        gnt_d           = gnt_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        issue_d         = issue_q;
        recv_d          = recv_q;
        bus.mem_en      = 1'b0;
        bus.mem_wr      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.fill_we     = '0;
        bus.fill_tag_we = '0;
        bus.fill_addr   = '0;
        bus.fill_data   = '0;
        case (state_q)
            IDLE: begin
                if (take) begin
                    gnt_d   = arb_gnt;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    issue_d = '0;
                    recv_d  = '0;
                    state_d = sel_write ? WRITE : FILL;
                end
            end
            FILL: begin
                // Issue and receive run independently; reads return in order
                if (issue_q < CW'(BLOCK_WORDS)) begin
                    bus.mem_en   = 1'b1;
                    bus.mem_addr = block_base + AW'(issue_q) * AW'(WB);
                    issue_d      = issue_q + 1'b1;
                end
                if (bus.mem_rvalid) begin
                    bus.fill_we   = gnt_q;
                    bus.fill_data = bus.mem_rdata;
                    bus.fill_addr = block_base + AW'(recv_q) * AW'(WB);
                    recv_d        = recv_q + 1'b1;
                    if (recv_q == CW'(BLOCK_WORDS - 1)) begin
                        bus.fill_tag_we = gnt_q;
                        state_d         = DONE;
                    end
                end
            end
            WRITE: begin
                bus.mem_en    = 1'b1;
                bus.mem_wr    = 1'b1;
                bus.mem_addr  = addr_q;
                bus.mem_wdata = wdata_q;
                state_d       = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state registers; reset aborts any transfer without a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            issue_q <= '0;
            recv_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            issue_q <= issue_d;
            recv_q  <= recv_d;
        end
    end

    // Latched request payload; only observed while a grant is active
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

endmodule

// File: tb/tb_mem_miss_arbiter.sv
// Directed bench for mem_miss_arbiter: a 2-port fixed-priority instance with
// a variable-latency memory model and a 4-port round-robin instance.
module tb_mem_miss_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_miss_arbiter_if #(.NPORTS(2), .AW(16), .DW(16)) b2 ();
    mem_miss_arbiter_if #(.NPORTS(4), .AW(16), .DW(16)) b4 ();

    mem_miss_arbiter #(.NPORTS(2), .AW(16), .DW(16), .BLOCK_WORDS(8), .PRIO_MODE(0)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (b2)
    );

    mem_miss_arbiter #(.NPORTS(4), .AW(16), .DW(16), .BLOCK_WORDS(8), .PRIO_MODE(1)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (b4)
    );

    // Memory model: read data = address ^ 0xC3C3, returned lat cycles after issue
    logic [2:0]  lat;
    logic [7:0]  pv;
    logic [15:0] pa [8];

    always @(posedge clk) begin
        if (rst) pv <= '0;
        else     pv <= {pv[6:0], b2.mem_en & ~b2.mem_wr};
        pa[0] <= b2.mem_addr;
        for (int i = 1; i < 8; i++) pa[i] <= pa[i-1];
    end

    assign b2.mem_rvalid = (lat == 3'd0) ? (b2.mem_en & ~b2.mem_wr) : pv[lat - 3'd1];
    assign b2.mem_rdata  = ((lat == 3'd0) ? b2.mem_addr : pa[lat - 3'd1]) ^ 16'hC3C3;
    assign b4.mem_rvalid = 1'b0;
    assign b4.mem_rdata  = '0;

    // A requester must hold req_valid until its done pulse
    logic [1:0] rv_q;
    logic       rs_q;
    always @(posedge clk) begin
        if (!rst && !rs_q)
            assert ((rv_q & ~b2.done & ~b2.req_valid) == 2'b00)
                else $error("req_valid dropped before done");
        rv_q <= b2.req_valid;
        rs_q <= rst;
    end

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int c0;
    int n_iss, n_wr, n_fwe, n_tag, n_done, n4;
    int wr_cyc, done_cyc, tag_word;
    logic [15:0] iss_addr [16];
    logic [15:0] fa [16];
    logic [15:0] fd [16];
    logic [15:0] wr_addr, wr_data;
    logic [1:0]  fwe_mask, tag_mask, done_mask, stall_at_done;
    logic [1:0]  dlog [4];
    int          dcyc [4];
    logic [3:0]  d4 [8];
    logic        stall1_drop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_iss = 0; n_wr = 0; n_fwe = 0; n_tag = 0; n_done = 0; n4 = 0;
        wr_cyc = -1; done_cyc = -1; tag_word = -1;
        fwe_mask = '0; tag_mask = '0; done_mask = '0; stall_at_done = 2'b11;
        stall1_drop = 1'b0;
    endtask

    // Advance to the next falling edge and record what both instances did
    task automatic step();
        @(negedge clk);
        cyc++;
        if (b2.mem_en && !b2.mem_wr) begin
            if (n_iss < 16) iss_addr[n_iss] = b2.mem_addr;
            n_iss++;
        end
        if (b2.mem_en && b2.mem_wr) begin
            n_wr++; wr_addr = b2.mem_addr; wr_data = b2.mem_wdata; wr_cyc = cyc;
        end
        if (b2.fill_we != 2'b00) begin
            fwe_mask = fwe_mask | b2.fill_we;
            if (n_fwe < 16) begin
                fa[n_fwe] = b2.fill_addr;
                fd[n_fwe] = b2.fill_data;
            end
            n_fwe++;
        end
        if (b2.fill_tag_we != 2'b00) begin
            n_tag++; tag_mask = tag_mask | b2.fill_tag_we; tag_word = n_fwe;
        end
        if (b2.done != 2'b00) begin
            if (n_done < 4) begin
                dlog[n_done] = b2.done;
                dcyc[n_done] = cyc;
            end
            n_done++; done_mask = b2.done; done_cyc = cyc; stall_at_done = b2.stall;
        end
        if (b2.req_valid[1] && !b2.stall[1] && !b2.done[1]) stall1_drop = 1'b1;
        if (b4.done != 4'h0) begin
            if (n4 < 8) d4[n4] = b4.done;
            n4++;
        end
    endtask

    task automatic wait2(input logic [1:0] mask, input int budget, input string tag);
        bit found;
        found = 1'b0;
        for (int k = 0; k < budget && !found; k++) begin
            step();
            if ((b2.done & mask) != 2'b00) found = 1'b1;
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    task automatic req2(input int p, input logic wr, input logic [15:0] addr, input logic [15:0] data);
        b2.req_addr[p*16 +: 16]  = addr;
        b2.req_wdata[p*16 +: 16] = data;
        b2.req_write[p]          = wr;
        b2.req_valid[p]          = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        lat = 3'd1;
        b2.req_valid = '0; b2.req_write = '0; b2.req_addr = '0; b2.req_wdata = '0;
        b4.req_valid = '0; b4.req_write = '0; b4.req_addr = '0; b4.req_wdata = '0;
        clr();
        repeat (3) step();
        chk("rst_mem", {30'd0, b2.mem_en, b2.mem_wr}, 32'd0);
        chk("rst_fill", {26'd0, b2.fill_we, b2.fill_tag_we, b2.done}, 32'd0);
        chk("rst_addr", {16'd0, b2.mem_addr}, 32'd0);
        chk("rst4_done", {28'd0, b4.done}, 32'd0);
        rst = 1'b0;
        step();
        chk("idle_mem_en", {31'd0, b2.mem_en}, 32'd0);
        chk("idle_stall", {30'd0, b2.stall}, 32'd0);

        // 1: block fill on port 1, memory latency 3
        clr(); lat = 3'd3; c0 = cyc;
        req2(1, 1'b0, 16'h1236, 16'h0000);
        step();
        chk("t1_stall", {30'd0, b2.stall}, 32'd2);
        wait2(2'b10, 40, "t1_timeout");
        b2.req_valid = '0;
        chk("t1_n_iss", n_iss, 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_iss%0d", i), {16'd0, iss_addr[i]}, 32'h1230 + 2*i);
            chk($sformatf("t1_fa%0d", i), {16'd0, fa[i]}, 32'h1230 + 2*i);
            chk($sformatf("t1_fd%0d", i), {16'd0, fd[i]}, (32'h1230 + 2*i) ^ 32'hC3C3);
        end
        chk("t1_n_fwe", n_fwe, 8);
        chk("t1_fwe_mask", {30'd0, fwe_mask}, 32'd2);
        chk("t1_n_tag", n_tag, 1);
        chk("t1_tag_word", tag_word, 8);
        chk("t1_tag_mask", {30'd0, tag_mask}, 32'd2);
        chk("t1_done_mask", {30'd0, done_mask}, 32'd2);
        chk("t1_latency", done_cyc - c0, 12);
        chk("t1_stall_at_done", {30'd0, stall_at_done}, 32'd0);
        repeat (2) step();

        // 2: port 0 fill and port 1 write in the same cycle, fixed priority
        clr(); lat = 3'd1; c0 = cyc;
        req2(0, 1'b0, 16'h2000, 16'h0000);
        req2(1, 1'b1, 16'h0040, 16'hBEEF);
        wait2(2'b01, 40, "t2_p0_timeout");
        b2.req_valid[0] = 1'b0;
        wait2(2'b10, 20, "t2_p1_timeout");
        b2.req_valid[1] = 1'b0;
        chk("t2_first", {30'd0, dlog[0]}, 32'd1);
        chk("t2_second", {30'd0, dlog[1]}, 32'd2);
        chk("t2_p0_latency", dcyc[0] - c0, 10);
        chk("t2_n_fwe", n_fwe, 8);
        chk("t2_fwe_mask", {30'd0, fwe_mask}, 32'd1);
        chk("t2_stall1_held", {31'd0, stall1_drop}, 32'd0);
        chk("t2_n_wr", n_wr, 1);
        chk("t2_wr_addr", {16'd0, wr_addr}, 32'h0040);
        chk("t2_wr_data", {16'd0, wr_data}, 32'hBEEF);
        chk("t2_wr_cyc", wr_cyc - dcyc[0], 2);
        chk("t2_p1_done_cyc", dcyc[1] - dcyc[0], 3);
        repeat (2) step();

        // 3: round-robin over 4 ports all requesting continuously
        clr();
        for (int i = 0; i < 4; i++) begin
            b4.req_addr[i*16 +: 16]  = 16'(16'h0100 * i);
            b4.req_wdata[i*16 +: 16] = 16'(16'h1111 * i);
        end
        b4.req_write = 4'hF;
        b4.req_valid = 4'hF;
        for (int k = 0; k < 40 && n4 < 5; k++) step();
        b4.req_valid = 4'h0;
        chk("t3_timeout", 32'(n4 >= 5), 32'd1);
        chk("t3_g0", {28'd0, d4[0]}, 32'h1);
        chk("t3_g1", {28'd0, d4[1]}, 32'h2);
        chk("t3_g2", {28'd0, d4[2]}, 32'h4);
        chk("t3_g3", {28'd0, d4[3]}, 32'h8);
        chk("t3_g4", {28'd0, d4[4]}, 32'h1);
        repeat (3) step();

        // 4: write-through store on port 1
        clr(); c0 = cyc;
        req2(1, 1'b1, 16'h0102, 16'hA5A5);
        wait2(2'b10, 10, "t4_timeout");
        b2.req_valid = '0;
        chk("t4_n_wr", n_wr, 1);
        chk("t4_wr_addr", {16'd0, wr_addr}, 32'h0102);
        chk("t4_wr_data", {16'd0, wr_data}, 32'hA5A5);
        chk("t4_wr_cyc", wr_cyc - c0, 1);
        chk("t4_done_cyc", done_cyc - c0, 2);
        chk("t4_done_mask", {30'd0, done_mask}, 32'd2);
        chk("t4_n_fwe", n_fwe, 0);
        chk("t4_n_iss", n_iss, 0);
        repeat (2) step();

        // 5: reset in the middle of a fill, then the held request refills
        clr(); lat = 3'd1;
        req2(0, 1'b0, 16'h3010, 16'h0000);
        for (int k = 0; k < 20 && n_fwe < 3; k++) step();
        chk("t5_reach3", n_fwe, 3);
        rst = 1'b1;
        step();
        chk("t5_mem", {30'd0, b2.mem_en, b2.mem_wr}, 32'd0);
        chk("t5_fill", {28'd0, b2.fill_we, b2.fill_tag_we}, 32'd0);
        chk("t5_done", {30'd0, b2.done}, 32'd0);
        chk("t5_mem_addr", {16'd0, b2.mem_addr}, 32'd0);
        chk("t5_stall", {30'd0, b2.stall}, 32'd1);
        chk("t5_no_done", n_done, 0);
        rst = 1'b0;
        clr(); c0 = cyc;
        wait2(2'b01, 40, "t5_timeout");
        b2.req_valid = '0;
        chk("t5_n_fwe", n_fwe, 8);
        chk("t5_fa0", {16'd0, fa[0]}, 32'h3010);
        chk("t5_fa7", {16'd0, fa[7]}, 32'h301E);
        chk("t5_n_done", n_done, 1);
        chk("t5_latency", dcyc[0] - c0, 10);
        repeat (2) step();

        // 6: zero-latency memory, last word returns with the last issue
        clr(); lat = 3'd0; c0 = cyc;
        req2(1, 1'b0, 16'h00F6, 16'h0000);
        wait2(2'b10, 30, "t6_timeout");
        b2.req_valid = '0;
        chk("t6_n_iss", n_iss, 8);
        chk("t6_n_fwe", n_fwe, 8);
        chk("t6_tag_word", tag_word, 8);
        chk("t6_n_tag", n_tag, 1);
        chk("t6_fa0", {16'd0, fa[0]}, 32'h00F0);
        chk("t6_fa7", {16'd0, fa[7]}, 32'h00FE);
        chk("t6_fd0", {16'd0, fd[0]}, 32'h00F0 ^ 32'hC3C3);
        chk("t6_fd7", {16'd0, fd[7]}, 32'h00FE ^ 32'hC3C3);
        chk("t6_latency", done_cyc - c0, 9);
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
